// File: rtl/decode_stage_if.sv
// Fetch-to-ALU decode bus: upstream fetch handshake, downstream decoded beat, flush.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_func3, out_func7, out_imm,
           out_rs1, out_rs2, out_rd, out_pc, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_imm,
           out_rs1, out_rs2, out_rd, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with output + skid buffer and flush.
// Optional illegal-encoding detection enabled by defining DECODE_ILLEGAL_EN.
module decode_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave i_bus
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } beat_t;

  logic [31:0]     w_i;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_imm_fin;
  logic            w_illegal;
  beat_t           w_dec;
  logic            w_acc;
  logic            w_rdy;

  beat_t r_out;
  beat_t r_skid;
  logic  r_out_vld;
  logic  r_skid_vld;

  assign w_i = i_bus.in_instr;

  always_comb begin
    w_imm = '0;
    case (w_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_imm = XLEN'($signed(w_i[31:20]));
      7'b0100011: w_imm = XLEN'($signed({w_i[31:25], w_i[11:7]}));
      7'b1100011: w_imm = XLEN'($signed({w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0}));
      7'b0110111, 7'b0010111: w_imm = XLEN'($signed({w_i[31:12], 12'b0}));
      7'b1101111: w_imm = XLEN'($signed({w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0}));
      default: w_imm = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  always_comb begin
    w_illegal = 1'b0;
    case (w_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111: w_illegal = 1'b0;
      7'b0110011: begin
        if (w_i[31:25] != 7'b0000000 && w_i[31:25] != 7'b0100000)
          w_illegal = 1'b1;
        else if (w_i[31:25] == 7'b0100000 && w_i[14:12] != 3'b000 && w_i[14:12] != 3'b101)
          w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end
  assign w_imm_fin = w_illegal ? '0 : w_imm;
`else
  assign w_illegal = 1'b0;
  assign w_imm_fin = w_imm;
`endif

  always_comb begin
    w_dec         = '0;
    w_dec.opcode  = w_i[6:0];
    w_dec.func3   = w_i[14:12];
    w_dec.func7   = w_i[31:25];
    w_dec.rs1     = w_i[19:15];
    w_dec.rs2     = w_i[24:20];
    w_dec.rd      = w_i[11:7];
    w_dec.imm     = w_imm_fin;
    w_dec.pc      = i_bus.in_pc;
    w_dec.illegal = w_illegal;
  end

  // Ready depends only on the skid register, so out_ready never reaches in_ready.
  assign w_rdy = ~r_skid_vld & ~rst;
  assign w_acc = i_bus.in_valid & w_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (i_bus.flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || i_bus.out_ready) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_acc;
        if (w_acc) r_out <= w_dec;
      end
    end else if (w_acc) begin
      r_skid     <= w_dec;
      r_skid_vld <= 1'b1;
    end
  end

  assign i_bus.in_ready    = w_rdy;
  assign i_bus.out_valid   = r_out_vld;
  assign i_bus.out_opcode  = r_out.opcode;
  assign i_bus.out_func3   = r_out.func3;
  assign i_bus.out_func7   = r_out.func7;
  assign i_bus.out_imm     = r_out.imm;
  assign i_bus.out_rs1     = r_out.rs1;
  assign i_bus.out_rs2     = r_out.rs2;
  assign i_bus.out_rd      = r_out.rd;
  assign i_bus.out_pc      = r_out.pc;
  assign i_bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: queue-based occupancy model checked every cycle,
// plus literal expectations for the documented instructions and corner cases.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic [96:0] q[$];

  decode_stage_if #(.XLEN(32)) bus();
  decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .i_bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected decoded beat from the ISA immediate rules, using signed integer arithmetic.
  function automatic logic [96:0] exp_beat(input logic [31:0] ins, input logic [31:0] pc);
    int   w;
    int   sgn;
    logic [31:0] imm;
    logic ill;
    logic [6:0] op;
    w   = int'(ins);
    sgn = w >>> 31;
    op  = ins[6:0];
    ill = 1'b0;
    case (op)
      7'h13, 7'h03, 7'h67: imm = w >>> 20;
      7'h23: imm = (w >>> 25) * 32 + int'(ins[11:7]);
      7'h63: imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      7'h37, 7'h17: imm = ins & 32'hFFFFF000;
      7'h6F: imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: imm = 32'h0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    if (!(op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33})) ill = 1'b1;
    if (op == 7'h33) begin
      if (!(ins[31:25] inside {7'h00, 7'h20})) ill = 1'b1;
      else if (ins[31:25] == 7'h20 && !(ins[14:12] inside {3'd0, 3'd5})) ill = 1'b1;
    end
    if (ill) imm = 32'h0;
`endif
    return {op, ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7], imm, pc, ill};
  endfunction

  function automatic logic [96:0] dut_beat();
    return {bus.out_opcode, bus.out_func3, bus.out_func7, bus.out_rs1, bus.out_rs2,
            bus.out_rd, bus.out_imm, bus.out_pc, bus.out_illegal};
  endfunction

  // Model: up to two beats in order; ready whenever fewer than two are held.
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (bus.flush) q.delete();
    else begin
      bit acc;
      acc = bus.in_valid && (q.size() < 2);
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (acc) q.push_back(exp_beat(bus.in_instr, bus.in_pc));
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 128'(bus.in_ready), 128'(!rst && q.size() < 2));
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    if (q.size() > 0) chk("beat", 128'(dut_beat()), 128'(q[0]));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  logic [31:0] tbl [8] = '{32'h00A00513, 32'h0040A103, 32'h0020A423, 32'hFE000EE3,
                           32'h12345037, 32'h008000EF, 32'h000080E7, 32'h402081B3};

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    step();
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_data", 128'(dut_beat()), 128'(0));
    rst = 1'b0;
    step();
    chk("ready_after_rst", 128'(bus.in_ready), 128'(1));

    // Documented instructions
    bus.out_ready = 1'b1;
    offer(32'hFFB00093, 32'h100);
    step();
    chk("addi_valid", 128'(bus.out_valid), 128'(1));
    chk("addi_op", 128'(bus.out_opcode), 128'(7'h13));
    chk("addi_rd", 128'(bus.out_rd), 128'(1));
    chk("addi_rs1", 128'(bus.out_rs1), 128'(0));
    chk("addi_f3", 128'(bus.out_func3), 128'(0));
    chk("addi_imm", 128'(bus.out_imm), 128'(32'hFFFFFFFB));
    chk("addi_pc", 128'(bus.out_pc), 128'(32'h100));
    offer(32'h402081B3, 32'h104);
    step();
    chk("sub_fields", 128'({bus.out_opcode, bus.out_func7, bus.out_func3, bus.out_rs1, bus.out_rs2, bus.out_rd}),
        128'({7'h33, 7'h20, 3'd0, 5'd1, 5'd2, 5'd3}));
    chk("sub_imm", 128'(bus.out_imm), 128'(0));
    offer(32'hFE000EE3, 32'h108);
    step();
    chk("beq_op", 128'(bus.out_opcode), 128'(7'h63));
    chk("beq_imm", 128'(bus.out_imm), 128'(32'hFFFFFFFC));
    offer(32'h12345037, 32'h10C);
    step();
    chk("lui_imm", 128'(bus.out_imm), 128'(32'h12345000));
    offer(32'h0020A423, 32'h110);
    step();
    chk("sw_imm", 128'(bus.out_imm), 128'(8));
    offer(32'h0000007F, 32'h114);
    step();
`ifdef DECODE_ILLEGAL_EN
    chk("illegal_flag", 128'(bus.out_illegal), 128'(1));
`else
    chk("illegal_flag", 128'(bus.out_illegal), 128'(0));
`endif
    chk("illegal_imm", 128'(bus.out_imm), 128'(0));
    offer(32'h02000033, 32'h118);
    step();
    offer(32'h40001033, 32'h11C);
    step();
    bus.in_valid = 1'b0;
    step();

    // Backpressure: A, B buffered, C held upstream
    bus.out_ready = 1'b0;
    offer(32'h00100093, 32'hA00);
    step();
    offer(32'h00200093, 32'hB00);
    step();
    chk("bp_ready_low", 128'(bus.in_ready), 128'(0));
    offer(32'h00300093, 32'hC00);
    step();
    chk("bp_hold_A", 128'(bus.out_pc), 128'(32'hA00));
    chk("bp_ready_still_low", 128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    step();
    chk("bp_out_B", 128'(bus.out_pc), 128'(32'hB00));
    step();
    chk("bp_out_C", 128'(bus.out_pc), 128'(32'hC00));
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", 128'(bus.out_valid), 128'(0));

    // Flush with two beats buffered while offering D
    bus.out_ready = 1'b0;
    offer(32'h00500093, 32'hE00);
    step();
    offer(32'h00600093, 32'hF00);
    step();
    bus.flush = 1'b1;
    offer(32'h00700093, 32'hD00);
    step();
    chk("flush_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_ready", 128'(bus.in_ready), 128'(1));
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("flush_no_D", 128'(bus.out_valid), 128'(0));
    // Flush while the output is transferring
    bus.out_ready = 1'b1;
    offer(32'h00800093, 32'h120);
    step();
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_xfer_empty", 128'(bus.out_valid), 128'(0));

    // Mixed valid/ready pattern across all formats
    for (int k = 0; k < 24; k++) begin
      bus.in_valid  = (k % 4) != 3;
      bus.out_ready = (k % 3) != 1;
      bus.in_instr  = tbl[k % 8];
      bus.in_pc     = 32'h200 + 32'(4 * k);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset mid-cycle with a valid output
    bus.out_ready = 1'b0;
    offer(32'h00900093, 32'h300);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("async_rst_ready", 128'(bus.in_ready), 128'(0));
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_ready", 128'(bus.in_ready), 128'(1));
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage that sits directly upstream of the ALU. It accepts fetched instruction/PC beats over a valid/ready handshake and splits each instruction into the `opcode`/`func3`/`func7`/`imm` fields the ALU consumes. It also extracts the register indices and generates the sign-extended immediate for every RV32I format. A two-entry (output + skid) buffer sustains one instruction per cycle under backpressure, and a flush input squashes all held beats.

## Interface
- `XLEN`, 32: width of PC and immediate datapath.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  drop all buffered beats; synchronous.
- `in_valid`  in  1  fetch beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  decoded beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_opcode`  out  7  `instr[6:0]`.
- `out_func3`  out  3  `instr[14:12]`.
- `out_func7`  out  7  `instr[31:25]`.
- `out_imm`  out  XLEN  generated immediate.
- `out_rs1` / `out_rs2` / `out_rd`  out  5 each  `instr[19:15]` / `[24:20]` / `[11:7]`.
- `out_pc`  out  XLEN  PC of the decoded beat.
- `out_illegal`  out  1  illegal-encoding flag (see Configuration).

## Operation
- Storage: output register (`out_*`, `out_valid`) plus one skid register (`skid_valid`, same fields).
- `in_ready = ~skid_valid & ~rst`.
- Accept = `in_valid & in_ready`. Decoding happens combinationally on `in_instr` before registering.
- Output-side transfer = `out_valid & out_ready`.
- Per cycle, in priority order:
  - `flush`: next `out_valid = 0`, `skid_valid = 0`. A beat accepted in the same cycle is discarded.
  - Output empty or transferring, and skid full: skid moves to output. A concurrent accept goes into skid. That cannot occur, because skid full forces `in_ready = 0`.
  - Output empty or transferring, and skid empty: an accepted beat goes to output. With no accept, `out_valid` becomes 0.
  - Output full and stalled: an accepted beat goes to skid, and `in_ready` falls the next cycle.
- Beat order is always preserved.
- Immediate generation, by opcode, sign-extended to XLEN:
  - `0010011`, `0000011`, `1100111` (I): `instr[31:20]`.
  - `0100011` (S): `{instr[31:25],instr[11:7]}`.
  - `1100011` (B): `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}`.
  - `0110111`, `0010111` (U): `{instr[31:12],12'b0}`, not extended.
  - `1101111` (J): `{instr[31],instr[19:12],instr[20],instr[30:21],1'b0}`.
  - R-type `0110011` and any other opcode: 0.
- Field outputs (`func3`/`func7`/`rs*`/`rd`) are the raw bit slices for every format.

## Timing
- Reset, asserted asynchronously: `out_valid = 0`, `skid_valid = 0`, `in_ready = 0`, all data outputs 0, `out_illegal = 0`.
- First cycle after reset release: `in_ready = 1`.
- Latency: an accept in cycle N gives `out_valid = 1` with that beat in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready = 1`.
- Backpressure: output data is held stable while `out_valid & ~out_ready`. At most 2 beats are buffered.
- `in_ready` is a function of registered state only; there is no combinational path from `out_ready`.
- `flush` together with `out_ready`: the output transfer completes in that cycle, and the stage is empty in the next cycle.
- Reset mid-operation: all buffered beats are lost immediately.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - `out_illegal` is registered alongside each beat.
  - It is set for: an opcode outside the nine listed; R-type with `func7` not `0000000`/`0100000`; R-type with `func7 = 0100000` and `func3` not `000`/`101`.
  - On an illegal beat, `out_imm` is forced to 0. Other fields pass unchanged.
- `DECODE_ILLEGAL_EN` undefined: `out_illegal` is tied to 0, no detection logic is built, and immediates are generated as above.

## Test plan
- `addi x1,x0,-5`:
  - Stimulus: `in_instr = 0xFFB00093`, `in_pc = 0x100`, accepted cycle N.
  - Response, cycle N+1: `out_valid = 1`, `out_opcode = 0x13`, `out_rd = 1`, `out_rs1 = 0`, `out_func3 = 0`, `out_imm = 0xFFFFFFFB`, `out_pc = 0x100`.
- `sub x3,x1,x2`:
  - Stimulus: `in_instr = 0x402081B3`.
  - Response: `out_opcode = 0x33`, `out_func7 = 0x20`, `out_func3 = 0`, `out_rs1 = 1`, `out_rs2 = 2`, `out_rd = 3`, `out_imm = 0`.
- `beq x0,x0,-4`:
  - Stimulus: `in_instr = 0xFE000EE3`.
  - Response: `out_opcode = 0x63`, `out_imm = 0xFFFFFFFC`.
- Backpressure:
  - Stimulus: hold `out_ready = 0`; offer beats A, B, C back-to-back.
  - Response: A and B are accepted; `in_ready = 0` from the cycle after B; C is held upstream. Then raise `out_ready` and check that A, B, C emerge in order on consecutive cycles with none lost.
- Flush:
  - Stimulus: with two beats buffered, assert `flush` for one cycle while offering beat D.
  - Response: next cycle `out_valid = 0` and `in_ready = 1`; D is never output.
- Illegal (with `DECODE_ILLEGAL_EN`):
  - Stimulus: `in_instr = 0x0000007F`.
  - Response: `out_illegal = 1`, `out_imm = 0`. Without the macro, `out_illegal = 0`.
- Async reset:
  - Stimulus: assert `rst` mid-cycle with a valid output.
  - Response: `out_valid` drops immediately.
